mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_timeout.sv | 32 +++
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: WB control bit positions, FSM encoding and
// the forwarding bus layout used by EX, MEM, WB and FORWARD.
package mem_stage_pkg;

    localparam int XLEN        = 32;
    localparam int RW_W        = 5;
    localparam int WB_CTRL_W   = 5;
    localparam int WB_REGWRITE = 4;
    localparam int WB_MEMTOREG = 3;
    localparam int MEM_DATA_W  = RW_W + XLEN + XLEN;
    localparam int BACK_W      = 1 + RW_W + XLEN;
    localparam int WB_DATA_W   = RW_W + XLEN;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic            valid;
        logic [RW_W-1:0] rw;
        logic [XLEN-1:0] data;
    } back_t;

    typedef struct packed {
        logic [RW_W-1:0] rw;
        logic [XLEN-1:0] ex_out;
        logic [XLEN-1:0] store_data;
    } mem_data_t;

    // A load is regWrite with memToReg; a store is flagged by memWrite.
    function automatic logic is_access(input logic mem_write,
                                       input logic [WB_CTRL_W-1:0] wb_ctrl);
        return mem_write || (wb_ctrl[WB_REGWRITE] && wb_ctrl[WB_MEMTOREG]);
    endfunction

    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;

    logic                           dmem_req;
    logic                           dmem_we;
    logic [mem_stage_pkg::XLEN-1:0] dmem_addr;
    logic [mem_stage_pkg::XLEN-1:0] dmem_wdata;
    logic                           dmem_ack;
    logic [mem_stage_pkg::XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_timeout.sv
// Counts cycles spent waiting for a bus ack; expired flags the last allowed
// WAIT cycle so the FSM can abort instead of stalling forever.
module mem_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [CNT_W-1:0] count_r;

    // Counter restarts from zero whenever the FSM is not staying in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (run) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= {CNT_W{1'b0}};
        end
    end

    assign expired = in_wait && (count_r == CNT_LAST);

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-memory accesses, stalls the front end
// until ack, and registers the result into WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_FLUSH,
    input  logic                  MEM_CTRL,
    input  logic [WB_CTRL_W-1:0]  WB_CTRL,
    input  logic [MEM_DATA_W-1:0] MEM_DATA,
    mem_stage_if.master           dmem,
    output logic                  MEM_STALL,
    output logic [BACK_W-1:0]     MEM_BACK,
    output logic [WB_CTRL_W-1:0]  o_WB_CTRL,
    output logic [WB_DATA_W-1:0]  o_WB_DATA,
    output logic                  o_MEM_EXC
);

    mem_data_t            in_s;
    logic                 access_s;
    logic                 misaligned_s;
    mem_state_e           state_r;
    mem_state_e           next_state_s;
    logic                 req_s;
    logic                 we_s;
    logic [XLEN-1:0]      addr_s;
    logic [XLEN-1:0]      wdata_s;
    logic                 stall_s;
    logic                 commit_s;
    logic                 exc_s;
    logic                 latch_s;
    logic                 fwd_ok_s;
    logic [WB_CTRL_W-1:0] cur_ctrl_s;
    logic [RW_W-1:0]      cur_rw_s;
    logic [XLEN-1:0]      cur_ex_s;
    logic [XLEN-1:0]      result_s;
    logic                 expired_s;
    logic                 in_wait_s;
    logic                 run_s;
    back_t                back_s;

    // Copy of the outstanding access so the bus stays stable through WAIT.
    logic                 we_r;
    logic [XLEN-1:0]      ex_r;
    logic [XLEN-1:0]      wdata_r;
    logic [WB_CTRL_W-1:0] ctrl_r;
    logic [RW_W-1:0]      rw_r;

    assign in_s         = MEM_DATA;
    assign access_s     = is_access(MEM_CTRL, WB_CTRL);
    assign misaligned_s = (in_s.ex_out[1:0] != 2'b00);
    assign in_wait_s    = (state_r == ST_WAIT);
    assign run_s        = in_wait_s && (next_state_s == ST_WAIT);

    mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .in_wait (in_wait_s),
        .run     (run_s),
        .expired (expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, bus drive and WB-commit decisions.
    always_comb begin
        next_state_s = state_r;
        req_s        = 1'b0;
        we_s         = 1'b0;
        addr_s       = {XLEN{1'b0}};
        wdata_s      = {XLEN{1'b0}};
        stall_s      = 1'b0;
        commit_s     = 1'b0;
        exc_s        = 1'b0;
        latch_s      = 1'b0;
        fwd_ok_s     = 1'b0;
        cur_ctrl_s   = WB_CTRL;
        cur_rw_s     = in_s.rw;
        cur_ex_s     = in_s.ex_out;
        result_s     = in_s.ex_out;
        case (state_r)
            ST_IDLE: begin
                if (MEM_FLUSH) begin
                    next_state_s = ST_IDLE;
                end else if (!access_s) begin
                    commit_s = 1'b1;
                    fwd_ok_s = 1'b1;
                end else if (misaligned_s) begin
                    exc_s = 1'b1;
                end else begin
                    req_s    = 1'b1;
                    we_s     = MEM_CTRL;
                    addr_s   = word_addr(in_s.ex_out);
                    wdata_s  = in_s.store_data;
                    fwd_ok_s = 1'b1;
                    if (dmem.dmem_ack) begin
                        commit_s = 1'b1;
                        result_s = MEM_CTRL ? in_s.ex_out : dmem.dmem_rdata;
                    end else begin
                        stall_s      = 1'b1;
                        latch_s      = 1'b1;
                        next_state_s = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Flush is deliberately ignored here: the bus transfer must finish.
                cur_ctrl_s = ctrl_r;
                cur_rw_s   = rw_r;
                cur_ex_s   = ex_r;
                result_s   = ex_r;
                req_s      = 1'b1;
                we_s       = we_r;
                addr_s     = word_addr(ex_r);
                wdata_s    = wdata_r;
                fwd_ok_s   = 1'b1;
                if (dmem.dmem_ack) begin
                    commit_s     = 1'b1;
                    result_s     = we_r ? ex_r : dmem.dmem_rdata;
                    next_state_s = ST_IDLE;
                end else if (expired_s) begin
                    exc_s        = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Latch the access when it has to wait for the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            ex_r    <= {XLEN{1'b0}};
            wdata_r <= {XLEN{1'b0}};
            ctrl_r  <= {WB_CTRL_W{1'b0}};
            rw_r    <= {RW_W{1'b0}};
        end else if (latch_s) begin
            we_r    <= MEM_CTRL;
            ex_r    <= in_s.ex_out;
            wdata_r <= in_s.store_data;
            ctrl_r  <= WB_CTRL;
            rw_r    <= in_s.rw;
        end else begin
            we_r    <= we_r;
            ex_r    <= ex_r;
            wdata_r <= wdata_r;
            ctrl_r  <= ctrl_r;
            rw_r    <= rw_r;
        end
    end

    // MEM/WB register: anything that is not a commit becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_WB_CTRL <= {WB_CTRL_W{1'b0}};
            o_WB_DATA <= {WB_DATA_W{1'b0}};
            o_MEM_EXC <= 1'b0;
        end else begin
            o_MEM_EXC <= exc_s;
            if (commit_s) begin
                o_WB_CTRL <= cur_ctrl_s;
                o_WB_DATA <= {cur_rw_s, result_s};
            end else begin
                o_WB_CTRL <= {WB_CTRL_W{1'b0}};
                o_WB_DATA <= o_WB_DATA;
            end
        end
    end

    assign back_s.valid = fwd_ok_s && !rst && cur_ctrl_s[WB_REGWRITE] && !cur_ctrl_s[WB_MEMTOREG];
    assign back_s.rw    = cur_rw_s;
    assign back_s.data  = cur_ex_s;
    assign MEM_BACK     = back_s;

    assign dmem.dmem_req   = req_s && !rst;
    assign dmem.dmem_we    = we_s;
    assign dmem.dmem_addr  = addr_s;
    assign dmem.dmem_wdata = wdata_s;
    assign MEM_STALL       = stall_s && !rst;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected WB commits plus
// per-scenario checks of the bus, stall and forwarding outputs.
module tb_mem_stage;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [36:0] data;
        logic        exc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        MEM_FLUSH;
    logic        MEM_CTRL;
    logic [4:0]  WB_CTRL;
    logic [68:0] MEM_DATA;
    logic        MEM_STALL;
    logic [37:0] MEM_BACK;
    logic [4:0]  o_WB_CTRL;
    logic [36:0] o_WB_DATA;
    logic        o_MEM_EXC;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_compared;
    int   n_mismatched;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_FLUSH (MEM_FLUSH),
        .MEM_CTRL  (MEM_CTRL),
        .WB_CTRL   (WB_CTRL),
        .MEM_DATA  (MEM_DATA),
        .dmem      (bus),
        .MEM_STALL (MEM_STALL),
        .MEM_BACK  (MEM_BACK),
        .o_WB_CTRL (o_WB_CTRL),
        .o_WB_DATA (o_WB_DATA),
        .o_MEM_EXC (o_MEM_EXC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every non-bubble WB output or exception pulse pops one entry.
    always @(negedge clk) begin
        if (!rst && (o_WB_CTRL !== 5'd0 || o_MEM_EXC !== 1'b0)) begin
            n_compared++;
            if (sb_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL wb_unexpected got ctrl=%b data=%h exc=%b want nothing", o_WB_CTRL, o_WB_DATA, o_MEM_EXC);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_WB_CTRL !== mon_e.ctrl || o_MEM_EXC !== mon_e.exc ||
                    (mon_e.ctrl != 5'd0 && o_WB_DATA !== mon_e.data)) begin
                    n_mismatched++;
                    $display("FAIL wb_commit got ctrl=%b data=%h exc=%b want ctrl=%b data=%h exc=%b",
                             o_WB_CTRL, o_WB_DATA, o_MEM_EXC, mon_e.ctrl, mon_e.data, mon_e.exc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic flush, input logic mw, input logic [4:0] wb,
                         input logic [4:0] rw, input logic [31:0] ex, input logic [31:0] sd,
                         input logic ack, input logic [31:0] rd);
        MEM_FLUSH      = flush;
        MEM_CTRL       = mw;
        WB_CTRL        = wb;
        MEM_DATA       = {rw, ex, sd};
        bus.dmem_ack   = ack;
        bus.dmem_rdata = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'b11000, 5'd1, 32'h80, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        n_compared++;
        if (bus.dmem_req !== 1'b0 || MEM_STALL !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_bus got req=%b stall=%b want 0 0", bus.dmem_req, MEM_STALL);
        end
        n_compared++;
        if (o_WB_CTRL !== 5'd0 || o_WB_DATA !== 37'd0 || o_MEM_EXC !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_out got ctrl=%b data=%h exc=%b want 0 0 0", o_WB_CTRL, o_WB_DATA, o_MEM_EXC);
        end
        step();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_alu();
        step();
        drive(1'b0, 1'b0, 5'b10000, 5'd7, 32'h42, 32'h11, 1'b0, 32'd0);
        sb_q.push_back({5'b10000, 5'd7, 32'h42, 1'b0});
        @(negedge clk);
        n_compared++;
        if (MEM_BACK !== {1'b1, 5'd7, 32'h42}) begin
            n_mismatched++;
            $display("FAIL alu_back got %h want %h", MEM_BACK, {1'b1, 5'd7, 32'h42});
        end
        n_compared++;
        if (bus.dmem_req !== 1'b0 || MEM_STALL !== 1'b0) begin
            n_mismatched++;
            $display("FAIL alu_bus got req=%b stall=%b want 0 0", bus.dmem_req, MEM_STALL);
        end
        step();
        idle();
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL alu_drain got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_load_same_cycle();
        step();
        drive(1'b0, 1'b0, 5'b11000, 5'd5, 32'h200, 32'd0, 1'b1, 32'h12345678);
        sb_q.push_back({5'b11000, 5'd5, 32'h12345678, 1'b0});
        @(negedge clk);
        n_compared++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h200 || MEM_STALL !== 1'b0) begin
            n_mismatched++;
            $display("FAIL load0_bus got req=%b we=%b addr=%h stall=%b want 1 0 200 0",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, MEM_STALL);
        end
        n_compared++;
        if (MEM_BACK[37] !== 1'b0) begin
            n_mismatched++;
            $display("FAIL load0_back_valid got %b want 0", MEM_BACK[37]);
        end
        step();
        idle();
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL load0_drain got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_store_delayed();
        int stalls;
        stalls = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b0, 1'b1, 5'b00101, 5'd3, 32'h100, 32'hDEADBEEF, (k == 3), 32'hFFFF0000);
            if (k == 3) sb_q.push_back({5'b00101, 5'd3, 32'h100, 1'b0});
            @(negedge clk);
            if (MEM_STALL === 1'b1) stalls++;
            n_compared++;
            if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_addr !== 32'h100 ||
                bus.dmem_wdata !== 32'hDEADBEEF) begin
                n_mismatched++;
                $display("FAIL store_bus k=%0d got req=%b we=%b addr=%h wdata=%h want 1 1 100 deadbeef",
                         k, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata);
            end
            n_compared++;
            if (MEM_STALL !== (k < 3)) begin
                n_mismatched++;
                $display("FAIL store_stall k=%0d got %b want %b", k, MEM_STALL, (k < 3));
            end
        end
        n_compared++;
        if (stalls != 3) begin
            n_mismatched++;
            $display("FAIL store_stall_count got %0d want 3", stalls);
        end
        step();
        idle();
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL store_drain got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_misaligned();
        step();
        drive(1'b0, 1'b0, 5'b11000, 5'd9, 32'h102, 32'd0, 1'b0, 32'd0);
        sb_q.push_back({5'd0, 37'd0, 1'b1});
        @(negedge clk);
        n_compared++;
        if (bus.dmem_req !== 1'b0 || MEM_STALL !== 1'b0) begin
            n_mismatched++;
            $display("FAIL misalign_load got req=%b stall=%b want 0 0", bus.dmem_req, MEM_STALL);
        end
        step();
        drive(1'b0, 1'b1, 5'b00101, 5'd2, 32'h3, 32'h55, 1'b0, 32'd0);
        sb_q.push_back({5'd0, 37'd0, 1'b1});
        @(negedge clk);
        n_compared++;
        if (bus.dmem_req !== 1'b0 || MEM_STALL !== 1'b0) begin
            n_mismatched++;
            $display("FAIL misalign_store got req=%b stall=%b want 0 0", bus.dmem_req, MEM_STALL);
        end
        step();
        idle();
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL misalign_drain got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 5; k++) begin
            step();
            drive(1'b0, 1'b0, 5'b11000, 5'd2, 32'h300, 32'd0, 1'b0, 32'hCAFE0000);
            if (k == 4) sb_q.push_back({5'd0, 37'd0, 1'b1});
            @(negedge clk);
            n_compared++;
            if (MEM_STALL !== (k < 4) || bus.dmem_req !== 1'b1) begin
                n_mismatched++;
                $display("FAIL timeout_k k=%0d got stall=%b req=%b want %b 1", k, MEM_STALL, bus.dmem_req, (k < 4));
            end
        end
        step();
        idle();
        @(negedge clk);
        n_compared++;
        if (bus.dmem_req !== 1'b0 || MEM_STALL !== 1'b0) begin
            n_mismatched++;
            $display("FAIL timeout_idle got req=%b stall=%b want 0 0", bus.dmem_req, MEM_STALL);
        end
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL timeout_drain got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_flush();
        step();
        drive(1'b1, 1'b0, 5'b10000, 5'd4, 32'h10, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        n_compared++;
        if (MEM_BACK[37] !== 1'b0 || bus.dmem_req !== 1'b0) begin
            n_mismatched++;
            $display("FAIL flush_alu got valid=%b req=%b want 0 0", MEM_BACK[37], bus.dmem_req);
        end
        step();
        drive(1'b1, 1'b0, 5'b11000, 5'd4, 32'h20, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        n_compared++;
        if (bus.dmem_req !== 1'b0 || MEM_STALL !== 1'b0) begin
            n_mismatched++;
            $display("FAIL flush_load got req=%b stall=%b want 0 0", bus.dmem_req, MEM_STALL);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            drive((k != 0), 1'b1, 5'b00101, 5'd1, 32'h40, 32'hA5A5A5A5, (k == 2), 32'd0);
            if (k == 2) sb_q.push_back({5'b00101, 5'd1, 32'h40, 1'b0});
            @(negedge clk);
            n_compared++;
            if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h40 || MEM_STALL !== (k < 2)) begin
                n_mismatched++;
                $display("FAIL flush_wait k=%0d got req=%b addr=%h stall=%b want 1 40 %b",
                         k, bus.dmem_req, bus.dmem_addr, MEM_STALL, (k < 2));
            end
        end
        step();
        idle();
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL flush_drain got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_in_wait();
        for (int k = 0; k < 3; k++) begin
            step();
            rst = (k == 2);
            drive(1'b0, 1'b0, 5'b11000, 5'd6, 32'h50, 32'd0, 1'b0, 32'd0);
            @(negedge clk);
            n_compared++;
            if (bus.dmem_req !== (k < 2)) begin
                n_mismatched++;
                $display("FAIL rstwait_req k=%0d got %b want %b", k, bus.dmem_req, (k < 2));
            end
        end
        step();
        rst = 1'b0;
        idle();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        n_compared++;
        if (bus.dmem_req !== 1'b0 || MEM_STALL !== 1'b0 || o_WB_CTRL !== 5'd0 ||
            o_WB_DATA !== 37'd0 || o_MEM_EXC !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rstwait_out got req=%b stall=%b ctrl=%b data=%h exc=%b want all 0",
                     bus.dmem_req, MEM_STALL, o_WB_CTRL, o_WB_DATA, o_MEM_EXC);
        end
        step();
        idle();
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0 || o_WB_CTRL !== 5'd0) begin
            n_mismatched++;
            $display("FAIL rstwait_stray got pending=%0d ctrl=%b want 0 0", sb_q.size(), o_WB_CTRL);
            sb_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex;
        logic [31:0] rd;
        logic [4:0]  rw;
        logic [2:0]  spare;
        int          op;
        for (int i = 0; i < 8; i++) begin
            op    = int'($urandom_range(0, 2));
            ex    = $urandom;
            ex    = {ex[31:2], 2'b00};
            rd    = $urandom;
            rw    = 5'($urandom);
            spare = 3'($urandom);
            step();
            if (op == 0) begin
                drive(1'b0, 1'b0, {2'b10, spare}, rw, ex, 32'd0, 1'b0, rd);
                sb_q.push_back({2'b10, spare, rw, ex, 1'b0});
            end else if (op == 1) begin
                drive(1'b0, 1'b0, {2'b11, spare}, rw, ex, 32'd0, 1'b1, rd);
                sb_q.push_back({2'b11, spare, rw, rd, 1'b0});
            end else begin
                drive(1'b0, 1'b1, 5'b00111, rw, ex, rd, 1'b1, 32'd0);
                sb_q.push_back({5'b00111, rw, ex, 1'b0});
            end
            @(negedge clk);
            n_compared++;
            if (MEM_STALL !== 1'b0 || bus.dmem_req !== (op != 0) || (op != 0 && bus.dmem_addr !== ex)) begin
                n_mismatched++;
                $display("FAIL b2b_bus i=%0d op=%0d got stall=%b req=%b addr=%h want 0 %b %h",
                         i, op, MEM_STALL, bus.dmem_req, bus.dmem_addr, (op != 0), ex);
            end
        end
        step();
        idle();
        @(posedge clk);
        #2;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL b2b_drain got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        idle();
        test_reset();
        test_alu();
        test_load_same_cycle();
        test_store_delayed();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
